// File: rtl/i2c_bus_capture.sv
// ---------------------------------------------------------------------------
// i2c_bus_capture
//   Passive I2C bus monitor. Synchronizes scl/sda into the clk domain,
//   detects START / STOP, and collects data bytes in pairs. Each pair is
//   presented as one 16-bit word together with its two ACK bits.
//
// Ports
//   clk          system clock, must run at least 8x the SCL frequency
//   rst          synchronous active-high reset
//   scl, sda     raw bus lines, asynchronous to clk
//   o_data       last captured word, first byte in [15:8], second in [7:0]
//   o_data_valid one-cycle pulse when o_data / o_ack update
//   o_ack        ACK bits of the word, [1] first byte, [0] second byte
//   o_busy       high from a START until the next STOP
//   o_frame_err  one-cycle pulse when a STOP / repeated START cuts a word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_bus_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda,
  output logic [15:0] o_data,
  output logic        o_data_valid,
  output logic [1:0]  o_ack,
  output logic        o_busy,
  output logic        o_frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_d_r;
  logic                   sda_d_r;

  logic scl_s, sda_s;
  logic start_s, stop_s, scl_rise_s, scl_fall_s;
  logic trunc_s;
  logic [2:0] pend_bits_s;

  state_t      state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic        byte_idx_r, byte_idx_s;
  logic        pend_r, pend_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  byte0_r, byte0_s;
  logic        ack0_r, ack0_s;
  logic [15:0] data_r, data_s;
  logic [1:0]  ack_r, ack_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        ferr_r, ferr_s;

  // Synchronizer chains plus one delayed copy for edge detection; reset to idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_d_r    <= scl_sync_r[SYNC_STAGES-1];
      sda_d_r    <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign start_s    = scl_s & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & ~sda_d_r & sda_s;
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;

  // A STOP or repeated START is always preceded by an scl rise that the
  // shifter samples as a data bit. pend_r marks such a bit whose high phase
  // is still running, so it is not counted as received data when judging
  // whether the condition cut a word short.
  assign pend_bits_s = {2'b00, pend_r};
  assign trunc_s     = byte_idx_r
                     | ((state_r == BITS) & (bit_cnt_r != pend_bits_s))
                     | ((state_r == ACK) & pend_r);

  // Next-state and next-output logic; bus conditions outrank bit sampling.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    byte_idx_s = byte_idx_r;
    pend_s     = pend_r;
    shift_s    = shift_r;
    byte0_s    = byte0_r;
    ack0_s     = ack0_r;
    data_s     = data_r;
    ack_s      = ack_r;
    valid_s    = 1'b0;
    busy_s     = busy_r;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s    = BITS;
          bit_cnt_s  = 3'd0;
          byte_idx_s = 1'b0;
          pend_s     = 1'b0;
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BITS, ACK: begin
        if (stop_s) begin
          state_s    = IDLE;
          bit_cnt_s  = 3'd0;
          byte_idx_s = 1'b0;
          pend_s     = 1'b0;
          busy_s     = 1'b0;
          ferr_s     = trunc_s;
        end else if (start_s) begin
          state_s    = BITS;
          bit_cnt_s  = 3'd0;
          byte_idx_s = 1'b0;
          pend_s     = 1'b0;
          ferr_s     = trunc_s;
        end else if (scl_rise_s) begin
          if (state_r == BITS) begin
            shift_s = {shift_r[6:0], sda_s};
            pend_s  = 1'b1;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s = 3'd0;
              state_s   = ACK;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            pend_s  = 1'b0;
            state_s = BITS;
            if (!byte_idx_r) begin
              byte0_s    = shift_r;
              ack0_s     = sda_s;
              byte_idx_s = 1'b1;
            end else begin
              data_s     = {byte0_r, shift_r};
              ack_s      = {ack0_r, sda_s};
              valid_s    = 1'b1;
              byte_idx_s = 1'b0;
            end
          end
        end else if (scl_fall_s) begin
          pend_s = 1'b0;
        end else begin
          pend_s = pend_r;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Capture state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 1'b0;
      pend_r     <= 1'b0;
      shift_r    <= 8'h00;
      byte0_r    <= 8'h00;
      ack0_r     <= 1'b0;
      data_r     <= 16'h0000;
      ack_r      <= 2'b00;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      ferr_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_idx_r <= byte_idx_s;
      pend_r     <= pend_s;
      shift_r    <= shift_s;
      byte0_r    <= byte0_s;
      ack0_r     <= ack0_s;
      data_r     <= data_s;
      ack_r      <= ack_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
      ferr_r     <= ferr_s;
    end
  end

  assign o_data       = data_r;
  assign o_ack        = ack_r;
  assign o_data_valid = valid_r;
  assign o_busy       = busy_r;
  assign o_frame_err  = ferr_r;

endmodule

// File: tb/tb_i2c_bus_capture.sv
`timescale 1ns/1ps
module tb_i2c_bus_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda = 1'b1;
  logic [15:0] o_data, o_data3;
  logic        o_data_valid, o_data_valid3;
  logic [1:0]  o_ack, o_ack3;
  logic        o_busy, o_busy3;
  logic        o_frame_err, o_frame_err3;

  int checks = 0;
  int errors = 0;

  // Observed (monitor) and expected (transaction model) records.
  logic [15:0] got_data_q[$];
  logic [1:0]  got_ack_q[$];
  int          got_fe = 0;
  logic [15:0] exp_data_q[$];
  logic [1:0]  exp_ack_q[$];
  int          exp_fe = 0;

  i2c_bus_capture #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_ack(o_ack),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  i2c_bus_capture #(.SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .o_data(o_data3), .o_data_valid(o_data_valid3), .o_ack(o_ack3),
    .o_busy(o_busy3), .o_frame_err(o_frame_err3)
  );

  always #5 clk = ~clk;

  // Monitor: record every word pulse and frame-error pulse of the main instance.
  always @(negedge clk) begin
    if (o_data_valid) begin
      got_data_q.push_back(o_data);
      got_ack_q.push_back(o_ack);
    end
    if (o_frame_err) got_fe++;
  end

  // ---------------- bus driver (quarter SCL period = 4 clk) ----------------
  task automatic q_wait();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    q_wait();
    scl = 1'b1;
    q_wait();
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  // START or repeated START (works from idle bus or from scl low).
  task automatic send_start();
    sda = 1'b1;
    q_wait();
    scl = 1'b1;
    q_wait();
    sda = 1'b0;
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic send_stop();
    sda = 1'b0;
    q_wait();
    scl = 1'b1;
    q_wait();
    sda = 1'b1;
    q_wait();
    q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(a);
  endtask

  // A complete word on the wire; the model expects exactly this word back.
  task automatic send_word(input logic [7:0] b0, input logic a0,
                           input logic [7:0] b1, input logic a1);
    send_byte(b0, a0);
    send_byte(b1, a1);
    exp_data_q.push_back({b0, b1});
    exp_ack_q.push_back({a0, a1});
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", o_data); end
    checks++; if (o_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", o_ack); end
    checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_data_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", o_frame_err); end
    rst = 1'b0;
    q_wait();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_basic();
    int gb = got_data_q.size();
    int fb = got_fe;
    send_start();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b exp 1", o_busy); end
    send_word(8'hA5, 1'b0, 8'h3C, 1'b1);
    send_stop();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_stop got %b exp 0", o_busy); end
    checks++; if (got_data_q.size() - gb !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", got_data_q.size() - gb); end
    else begin
      checks++; if (got_data_q[gb] !== 16'hA53C) begin errors++; $display("FAIL basic_data got %h exp a53c", got_data_q[gb]); end
      checks++; if (got_ack_q[gb] !== 2'b01) begin errors++; $display("FAIL basic_ack got %b exp 01", got_ack_q[gb]); end
    end
    checks++; if (got_fe - fb !== 0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", got_fe - fb); end
  endtask

  task automatic test_back_to_back();
    int gb = got_data_q.size();
    int fb = got_fe;
    send_start();
    send_word(8'h12, 1'b0, 8'h34, 1'b0);
    send_word(8'h56, 1'b0, 8'h78, 1'b0);
    send_stop();
    checks++; if (got_data_q.size() - gb !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_data_q.size() - gb); end
    else begin
      checks++; if (got_data_q[gb] !== 16'h1234) begin errors++; $display("FAIL b2b_word0 got %h exp 1234", got_data_q[gb]); end
      checks++; if (got_data_q[gb+1] !== 16'h5678) begin errors++; $display("FAIL b2b_word1 got %h exp 5678", got_data_q[gb+1]); end
      checks++; if (got_ack_q[gb+1] !== 2'b00) begin errors++; $display("FAIL b2b_ack got %b exp 00", got_ack_q[gb+1]); end
    end
    checks++; if (got_fe - fb !== 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", got_fe - fb); end
  endtask

  task automatic test_truncated();
    int gb = got_data_q.size();
    int fb = got_fe;
    logic [15:0] prev = exp_data_q[$];
    send_start();
    send_byte(8'hFF, 1'b0);
    send_stop();
    exp_fe++;
    checks++; if (got_fe - fb !== 1) begin errors++; $display("FAIL trunc_ferr got %0d exp 1", got_fe - fb); end
    checks++; if (got_data_q.size() - gb !== 0) begin errors++; $display("FAIL trunc_valid got %0d exp 0", got_data_q.size() - gb); end
    checks++; if (o_data !== prev) begin errors++; $display("FAIL trunc_hold got %h exp %h", o_data, prev); end
  endtask

  task automatic test_repeated_start();
    int gb = got_data_q.size();
    int fb = got_fe;
    send_start();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    send_start();
    exp_fe++;
    checks++; if (got_fe - fb !== 1) begin errors++; $display("FAIL rs_ferr got %0d exp 1", got_fe - fb); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rs_busy got %b exp 1", o_busy); end
    send_word(8'h80, 1'b0, 8'h01, 1'b0);
    send_stop();
    checks++; if (got_data_q.size() - gb !== 1) begin errors++; $display("FAIL rs_count got %0d exp 1", got_data_q.size() - gb); end
    else begin
      checks++; if (got_data_q[gb] !== 16'h8001) begin errors++; $display("FAIL rs_data got %h exp 8001", got_data_q[gb]); end
    end
    checks++; if (got_fe - fb !== 1) begin errors++; $display("FAIL rs_ferr_total got %0d exp 1", got_fe - fb); end
  endtask

  task automatic test_reset_mid();
    int gb;
    int fb;
    logic [7:0] b0 = 8'h55;
    send_start();
    for (int i = 7; i >= 4; i--) send_bit(b0[i]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gb = got_data_q.size();
    fb = got_fe;
    for (int i = 3; i >= 0; i--) send_bit(b0[i]);
    send_bit(1'b0);
    send_byte(8'h66, 1'b0);
    checks++; if (got_data_q.size() - gb !== 0) begin errors++; $display("FAIL rstmid_valid got %0d exp 0", got_data_q.size() - gb); end
    checks++; if (got_fe - fb !== 0) begin errors++; $display("FAIL rstmid_ferr got %0d exp 0", got_fe - fb); end
    checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL rstmid_data got %h exp 0000", o_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", o_busy); end
    send_start();
    send_word(8'h55, 1'b0, 8'h66, 1'b0);
    send_stop();
    checks++; if (got_data_q.size() - gb !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got_data_q.size() - gb); end
    else begin
      checks++; if (got_data_q[gb] !== 16'h5566) begin errors++; $display("FAIL rstmid_word got %h exp 5566", got_data_q[gb]); end
    end
  endtask

  task automatic test_latency();
    int lat2 = -1;
    int lat3 = -1;
    logic [7:0] b1 = 8'hC3;
    send_start();
    send_byte(8'h5A, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b1[i]);
    sda = 1'b1;
    q_wait();
    scl = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (o_data_valid && lat2 < 0) lat2 = c;
      if (o_data_valid3 && lat3 < 0) lat3 = c;
    end
    scl = 1'b0;
    q_wait();
    exp_data_q.push_back(16'h5AC3);
    exp_ack_q.push_back(2'b01);
    send_stop();
    checks++; if (lat2 !== 3) begin errors++; $display("FAIL latency_s2 got %0d exp 3", lat2); end
    checks++; if (lat3 !== 4) begin errors++; $display("FAIL latency_s3 got %0d exp 4", lat3); end
    checks++; if (o_data3 !== 16'h5AC3) begin errors++; $display("FAIL latency_s3_data got %h exp 5ac3", o_data3); end
    checks++; if (o_ack3 !== 2'b01) begin errors++; $display("FAIL latency_s3_ack got %b exp 01", o_ack3); end
  endtask

  // Random frames: whole words, optional repeated STARTs between words, and
  // an optional truncated tail. Model: every whole word comes back in order;
  // every partial word ended by STOP / repeated START costs one frame error.
  task automatic test_random();
    int gb = got_data_q.size();
    int eb = exp_data_q.size();
    int fb = got_fe;
    int ef = exp_fe;
    int n;
    for (int f = 0; f < 14; f++) begin
      int nw = $urandom_range(0, 3);
      int tail = $urandom_range(0, 2);
      send_start();
      for (int w = 0; w < nw; w++) begin
        send_word(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) send_start();
      end
      if (tail == 1) begin
        int k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) send_bit(1'($urandom));
        exp_fe++;
      end else if (tail == 2) begin
        send_byte(8'($urandom), 1'($urandom));
        exp_fe++;
      end else begin
        tail = 0;
      end
      if ($urandom_range(0, 1) == 1) send_start();
      send_stop();
    end
    n = exp_data_q.size() - eb;
    checks++; if (got_data_q.size() - gb !== n) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_data_q.size() - gb, n); end
    else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_data_q[gb+i] !== exp_data_q[eb+i] || got_ack_q[gb+i] !== exp_ack_q[eb+i]) begin
          errors++;
          $display("FAIL rand_word%0d got %h/%b exp %h/%b", i, got_data_q[gb+i], got_ack_q[gb+i], exp_data_q[eb+i], exp_ack_q[eb+i]);
        end
      end
    end
    checks++; if (got_fe - fb !== exp_fe - ef) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", got_fe - fb, exp_fe - ef); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rand_busy got %b exp 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_truncated();
    test_repeated_start();
    test_latency();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_bus_capture.md
I2C_BUS_CAPTURE -- requirements
Module: i2c_bus_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on scl and sda (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock; samples the bus and must be at least 8x the SCL frequency.
REQ-003 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-004 SHALL have port scl, input, 1, raw I2C clock line (asynchronous to clk).
REQ-005 SHALL have port sda, input, 1, raw I2C data line (asynchronous to clk).
REQ-006 SHALL have port o_data, output, 16, last captured word: first byte in [15:8], second byte in [7:0], each MSB-first as on the wire.
REQ-007 SHALL have port o_data_valid, output, 1, one-cycle pulse when o_data updates.
REQ-008 SHALL have port o_ack, output, 2, ACK bits of the word: [1] for the first byte, [0] for the second byte (0 = ACK, 1 = NACK).
REQ-009 SHALL have port o_busy, output, 1, high from a START until the next STOP.
REQ-010 SHALL have port o_frame_err, output, 1, one-cycle pulse when a STOP or repeated START truncates a partial word.

Function
REQ-011 SHALL pass scl and sda through SYNC_STAGES flops; all detection uses the synchronized values and their one-cycle-delayed copies.
REQ-012 SHALL detect START as synchronized sda 1->0 while synchronized scl is 1, and STOP as sda 0->1 while scl is 1.
REQ-013 SHALL sample a data bit on each synchronized scl 0->1 edge only while in the BITS or ACK state.
REQ-014 SHALL implement the FSM states IDLE, BITS and ACK.
REQ-015 IDLE -> BITS on START, with the bit counter and byte index cleared and o_busy set.
REQ-016 BITS: shift sda into an 8-bit register MSB-first on each scl rise; after the 8th bit -> ACK.
REQ-017 ACK: on the scl rise, capture sda as the ACK bit and store the byte in slot byte index, then toggle byte index and return to BITS.
REQ-018 When the ACK of the second byte is captured, SHALL load o_data and o_ack and pulse o_data_valid in the same cycle.
REQ-019 Latency: o_data_valid SHALL be asserted SYNC_STAGES+1 clk cycles after the raw scl rise of the second ACK bit.
REQ-020 After a word completes, SHALL continue capturing into a new word (byte index 0) without waiting for START; a third byte begins the next word.
REQ-021 A repeated START in BITS or ACK SHALL clear the bit counter and byte index and stay in BITS; o_busy SHALL remain 1.
REQ-022 A STOP in any non-IDLE state SHALL go to IDLE and clear o_busy on the next cycle.
REQ-023 If a STOP or repeated START arrives while byte index = 1, or while bit counter != 0 in BITS, SHALL pulse o_frame_err for one cycle and SHALL NOT pulse o_data_valid.
REQ-024 START/STOP detection SHALL take priority over bit sampling in the same cycle.
REQ-025 o_data and o_ack SHALL hold their values between o_data_valid pulses.
REQ-026 SHALL ignore scl edges in IDLE.

Reset
REQ-027 While rst=1 at a clk rise, SHALL set: o_data=16'h0000, o_ack=2'b00, o_data_valid=0, o_busy=0, o_frame_err=0, FSM=IDLE, counters=0, synchronizer flops=1 (idle bus).
REQ-028 Reset asserted mid-transfer SHALL abandon the partial word with no o_data_valid or o_frame_err pulse; capture resumes only after a new START.

Verification
REQ-029 START, bytes 8'hA5 (ACK) and 8'h3C (NACK), STOP -> one o_data_valid pulse, o_data=16'hA53C, o_ack=2'b01, o_busy falls after STOP.
REQ-030 START, bytes 8'h12, 8'h34, 8'h56, 8'h78 (all ACK), STOP -> two pulses, with o_data 16'h1234 then 16'h5678, o_frame_err never set.
REQ-031 START, byte 8'hFF, ACK, then STOP -> o_frame_err single pulse, no o_data_valid, o_data keeps its prior value.
REQ-032 START, 5 bits, repeated START, bytes 8'h80 and 8'h01, STOP -> o_frame_err pulse at the repeated START, then o_data=16'h8001 valid.
REQ-033 rst pulsed after the 4th bit of the first byte, bus continues with 8'h55 and 8'h66 without a new START -> no outputs; after a new START with 8'h55 and 8'h66 -> o_data=16'h5566.
REQ-034 Check o_data_valid timing against REQ-019 for SYNC_STAGES=2 and 3 -> pulse 3 and 4 cycles respectively after the raw scl rise.
